// File: rtl/mux_rr_pkg.sv
// Shared definitions for the registered round-robin multiplexer:
// selection modes and the channel-count convention N = 2**SIZE_CTRL.
package mux_rr_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  function automatic int chan_count(input int size_ctrl);
    return 1 << size_ctrl;
  endfunction

endpackage

// File: rtl/mux_rr_if.sv
// Producer-side and consumer-side handshake bundle of mux_rr.
// master = environment driving the channels and consuming the output, slave = the mux.
interface mux_rr_if #(
  parameter int SIZE_CTRL = 2,
  parameter int WIRE      = 1
);
  localparam int N = 1 << SIZE_CTRL;

  logic [SIZE_CTRL-1:0] ctrl;
  logic [N-1:0]         in_valid;
  logic [N*WIRE-1:0]    in_data;
  logic [N-1:0]         in_ready;
  logic                 out_valid;
  logic [WIRE-1:0]      out_data;
  logic [SIZE_CTRL-1:0] out_sel;
  logic                 out_ready;

  modport master (
    output ctrl, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  ctrl, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/mux_rr_prio_enc.sv
// Rotating priority encoder: returns the first set request at or after ptr
// (wrapping modulo N) plus an any-request flag. Purely combinational.
module mux_rr_prio_enc #(
  parameter int SIZE_CTRL = 2
) (
  input  logic [(1<<SIZE_CTRL)-1:0] req_i,
  input  logic [SIZE_CTRL-1:0]      ptr_i,
  output logic [SIZE_CTRL-1:0]      grant_o,
  output logic                      any_o
);
  localparam int N = 1 << SIZE_CTRL;

  logic [N-1:0]         rot;
  logic [SIZE_CTRL-1:0] off;

  // rot[k] is the request k positions after ptr; index arithmetic wraps at N
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [SIZE_CTRL-1:0] src_idx;
    assign src_idx = ptr_i + SIZE_CTRL'(gi);
    assign rot[gi] = req_i[src_idx];
  end

  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = SIZE_CTRL'(i);
    end
  end

  assign grant_o = ptr_i + off;
  assign any_o   = |rot;
endmodule

// File: rtl/mux_rr.sv
// Registered N-to-1 multiplexer with valid/ready handshake and a one-entry
// output register; channel chosen by ctrl (MODE_FIXED) or round-robin (MODE_RR).
module mux_rr
  import mux_rr_pkg::*;
#(
  parameter int SIZE_CTRL = 2,
  parameter int WIRE      = 1,
  parameter int MODE      = MODE_FIXED
) (
  input logic  clk,
  input logic  rst,
  mux_rr_if.slave bus
);
  localparam int N = chan_count(SIZE_CTRL);

  logic                 load;
  logic                 req;
  logic                 xfer;
  logic [N-1:0]         req_vec;
  logic [SIZE_CTRL-1:0] ptr;
  logic [SIZE_CTRL-1:0] grant;
  logic [WIRE-1:0]      chan_data [N];

  logic                 out_valid_q, out_valid_d;
  logic [WIRE-1:0]      out_data_q,  out_data_d;
  logic [SIZE_CTRL-1:0] out_sel_q,   out_sel_d;

  // Fixed mode masks the request vector down to the ctrl channel so the same
  // encoder yields g = ctrl whenever that channel requests.
  if (MODE == MODE_RR) begin : g_rr
    logic [SIZE_CTRL-1:0] ptr_q, ptr_d;
    assign ptr_d = grant + SIZE_CTRL'(1);
    always_ff @(posedge clk) begin
      if (rst)       ptr_q <= '0;
      else if (xfer) ptr_q <= ptr_d;
    end
    assign ptr     = ptr_q;
    assign req_vec = bus.in_valid;
  end else begin : g_fix
    assign ptr     = '0;
    assign req_vec = bus.in_valid & (N'(1) << bus.ctrl);
  end

  mux_rr_prio_enc #(.SIZE_CTRL(SIZE_CTRL)) u_enc (
    .req_i   (req_vec),
    .ptr_i   (ptr),
    .grant_o (grant),
    .any_o   (req)
  );

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    assign chan_data[gi] = bus.in_data[gi*WIRE +: WIRE];
  end

  assign load = !out_valid_q || bus.out_ready;
  assign xfer = load && req && !rst;

  assign bus.in_ready = xfer ? (N'(1) << grant) : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = chan_data[grant];
      out_sel_d   = grant;
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_mux_rr.sv
// Scoreboard bench for mux_rr: one fixed-select and one round-robin instance
// driven side by side from directed per-cycle vectors.
module tb_mux_rr;
  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  mux_rr_if #(.SIZE_CTRL(2), .WIRE(8)) bus0 ();
  mux_rr_if #(.SIZE_CTRL(2), .WIRE(8)) bus1 ();

  mux_rr #(.SIZE_CTRL(2), .WIRE(8), .MODE(0)) u_fix (.clk(clk), .rst(rst), .bus(bus0));
  mux_rr #(.SIZE_CTRL(2), .WIRE(8), .MODE(1)) u_rr  (.clk(clk), .rst(rst), .bus(bus1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] oh);
    exp_t e;
    e.sel  = 2'd0;
    e.data = 8'hA0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) begin
        e.sel  = 2'(i);
        e.data = 8'hA0 + 8'(i);
      end
    end
    return e;
  endfunction

  // One clock cycle of stimulus; a nonzero expected in_ready means a transfer,
  // whose word is queued for the monitor.
  task automatic cyc(input logic r,
                     input logic [3:0] v0, input logic [1:0] c0, input logic rd0,
                     input logic [3:0] v1, input logic rd1,
                     input logic [3:0] er0, input logic [3:0] er1);
    @(posedge clk);
    #1;
    rst            = r;
    bus0.in_valid  = v0;
    bus0.ctrl      = c0;
    bus0.out_ready = rd0;
    bus1.in_valid  = v1;
    bus1.ctrl      = 2'd0;
    bus1.out_ready = rd1;
    if (r) begin
      q0.delete();
      q1.delete();
    end
    #1;
    check("in_ready_fix", 32'(bus0.in_ready), 32'(er0));
    check("in_ready_rr",  32'(bus1.in_ready), 32'(er1));
    if (er0 != 4'd0) q0.push_back(mk(er0));
    if (er1 != 4'd0) q1.push_back(mk(er1));
    $display("cyc t=%0t rst=%0b fix:v=%h c=%0d rdy=%0b ir=%h | rr:v=%h rdy=%0b ir=%h",
             $time, r, v0, c0, rd0, bus0.in_ready, v1, rd1, bus1.in_ready);
  endtask

  task automatic chk_out(input logic ov0, input logic [1:0] os0, input logic [7:0] od0,
                         input logic ov1, input logic [1:0] os1, input logic [7:0] od1);
    check("out_valid_fix", 32'(bus0.out_valid), 32'(ov0));
    check("out_sel_fix",   32'(bus0.out_sel),   32'(os0));
    check("out_data_fix",  32'(bus0.out_data),  32'(od0));
    check("out_valid_rr",  32'(bus1.out_valid), 32'(ov1));
    check("out_sel_rr",    32'(bus1.out_sel),   32'(os1));
    check("out_data_rr",   32'(bus1.out_data),  32'(od1));
  endtask

  // Monitors: a word is consumed on every edge where out_valid && out_ready.
  always @(negedge clk) begin
    if (bus0.out_valid && bus0.out_ready) begin
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_word_fix: got sel=%0d data=%h expected none", bus0.out_sel, bus0.out_data);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("pop_sel_fix",  32'(bus0.out_sel),  32'(e.sel));
        check("pop_data_fix", 32'(bus0.out_data), 32'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    if (bus1.out_valid && bus1.out_ready) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_word_rr: got sel=%0d data=%h expected none", bus1.out_sel, bus1.out_data);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("pop_sel_rr",  32'(bus1.out_sel),  32'(e.sel));
        check("pop_data_rr", 32'(bus1.out_data), 32'(e.data));
      end
    end
  end

  initial begin
    logic [3:0] skip_seq [4];
    logic [1:0] stall_ctrl [3];
    skip_seq   = '{4'b0001, 4'b0100, 4'b1000, 4'b0001};
    stall_ctrl = '{2'd0, 2'd1, 2'd3};

    bus0.in_data   = 32'hA3A2A1A0;
    bus1.in_data   = 32'hA3A2A1A0;
    bus0.in_valid  = 4'h0;
    bus1.in_valid  = 4'h0;
    bus0.ctrl      = 2'd0;
    bus1.ctrl      = 2'd0;
    bus0.out_ready = 1'b0;
    bus1.out_ready = 1'b0;

    // Reset held two cycles with every channel valid
    cyc(1, 4'hF, 0, 1, 4'hF, 1, 4'h0, 4'h0); chk_out(0, 0, 8'h00, 0, 0, 8'h00);
    cyc(1, 4'hF, 0, 1, 4'hF, 1, 4'h0, 4'h0); chk_out(0, 0, 8'h00, 0, 0, 8'h00);

    // Fixed select steps ctrl 0..3 twice; round-robin cycles 0,1,2,3,0,1,2,3
    cyc(0, 4'hF, 0, 1, 4'hF, 1, 4'h1, 4'h1); chk_out(0, 0, 8'h00, 0, 0, 8'h00);
    for (int k = 1; k < 8; k++) begin
      cyc(0, 4'hF, 2'(k % 4), 1, 4'hF, 1, 4'(1 << (k % 4)), 4'(1 << (k % 4)));
      if (k == 1) chk_out(1, 0, 8'hA0, 1, 0, 8'hA0);
    end

    // Channel 1 drops out: grants 0,2,3,0
    for (int j = 0; j < 4; j++) begin
      cyc(0, 4'h0, 0, 1, 4'b1101, 1, 4'h0, skip_seq[j]);
    end

    // Load A2 on both, then stall three cycles while ctrl wanders
    cyc(0, 4'hF, 1, 1, 4'hF, 1, 4'h2, 4'h2);
    cyc(0, 4'hF, 2, 1, 4'hF, 1, 4'h4, 4'h4);
    for (int s = 0; s < 3; s++) begin
      cyc(0, 4'hF, stall_ctrl[s], 0, 4'hF, 0, 4'h0, 4'h0);
      chk_out(1, 2, 8'hA2, 1, 2, 8'hA2);
    end
    cyc(0, 4'hF, 3, 1, 4'hF, 1, 4'h8, 4'h8); chk_out(1, 2, 8'hA2, 1, 2, 8'hA2);

    // Sparse traffic: move ptr to 1, then a lone channel-3 pulse wraps it to 0
    cyc(0, 4'h0, 0, 1, 4'b0001, 1, 4'h0, 4'h1);
    cyc(0, 4'h0, 0, 1, 4'b1000, 1, 4'h0, 4'h8);
    cyc(0, 4'h0, 0, 1, 4'h0,    1, 4'h0, 4'h0); chk_out(0, 3, 8'hA3, 1, 3, 8'hA3);
    cyc(0, 4'h0, 0, 1, 4'h0,    1, 4'h0, 4'h0); chk_out(0, 3, 8'hA3, 0, 3, 8'hA3);
    cyc(0, 4'hF, 2, 1, 4'hF,    1, 4'h4, 4'h1);

    // Reset while both hold a stalled word; ptr was 1 and must come back as 0
    cyc(0, 4'hF, 0, 0, 4'hF, 0, 4'h0, 4'h0); chk_out(1, 2, 8'hA2, 1, 0, 8'hA0);
    cyc(1, 4'hF, 0, 0, 4'hF, 0, 4'h0, 4'h0); chk_out(1, 2, 8'hA2, 1, 0, 8'hA0);
    cyc(0, 4'hF, 1, 1, 4'hF, 1, 4'h2, 4'h1); chk_out(0, 0, 8'h00, 0, 0, 8'h00);
    cyc(0, 4'h0, 0, 1, 4'h0, 1, 4'h0, 4'h0); chk_out(1, 1, 8'hA1, 1, 0, 8'hA0);
    cyc(0, 4'h0, 0, 1, 4'h0, 1, 4'h0, 4'h0); chk_out(0, 1, 8'hA1, 0, 0, 8'hA0);

    @(posedge clk);
    #1;
    check("drained_fix", 32'(q0.size()), 32'd0);
    check("drained_rr",  32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
